rechannelizer: RTL and testbench

Receive-side counterpart of the two-channel serializer. Accepts an Avalon-ST packet stream of NUM_CH words per frame (sop on channel 0, eop on channel NUM_CH-1) and reassembles each frame into one parallel word carrying all channels. It sits between the serial sample link and the per-channel DSP (I/Q) consumers. Frame-integrity checking and a single frame of buffering absorb downstream backpressure.

---
 rtl/rechannelizer_pkg.sv | 33 +++
 rtl/rechannelizer_frame_buffer.sv | 78 +++++++
 rtl/rechannelizer.sv | 187 ++++++++++++++++++
 tb/tb_rechannelizer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rechannelizer_pkg.sv
// ---------------------------------------------------------------------------
// rechannelizer_pkg
// Shared types and helpers for the rechannelizer (serial-to-parallel frame
// reassembly on the receive side of the two-channel sample link).
//   state_t       : frame FSM states
//   err_cause_t   : which error, if any, the current accepted beat raises
//   ERR_COUNT_MAX : saturation value of the error counter
//   ch_offset()   : bit offset of channel k inside a packed frame word
// ---------------------------------------------------------------------------
package rechannelizer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2,
        FULL    = 2'd3
    } state_t;

    typedef logic [1:0] err_cause_t;

    localparam err_cause_t ERR_NONE  = 2'd0;
    localparam err_cause_t ERR_NOSOP = 2'd1;
    localparam err_cause_t ERR_LEN   = 2'd2;

    localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

    // Channel k occupies bits [k*width +: width] of the parallel frame word.
    function automatic int unsigned ch_offset(input int unsigned ch,
                                              input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rechannelizer_frame_buffer.sv
// ---------------------------------------------------------------------------
// channel_frame_buffer
// Collect registers for one frame (NUM_CH samples) plus the output holding
// register with its valid/ready handshake.
//   clk, reset_n  : clock, synchronous active-low reset
//   wr_en/wr_idx/wr_data : write one sample into collect slot wr_idx
//   load_direct   : frame completes this cycle; wr_data is the last channel,
//                   the other channels come from the collect registers
//   load_held     : move the complete frame held in the collect registers
//                   into the output register
//   out_ready     : downstream accepts out_data
//   out_data/out_valid : output holding register
//   out_free      : output register is empty or drains this cycle
// ---------------------------------------------------------------------------
module channel_frame_buffer
    import rechannelizer_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int NUM_CH = 2,
    localparam int IDX_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     load_direct,
    input  logic                     load_held,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     out_free
);

    localparam int LAST_OFF = ch_offset(NUM_CH - 1, DATA_W);

    logic [DATA_W-1:0]        coll [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] coll_flat;
    logic [NUM_CH*DATA_W-1:0] direct_frame;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_flat
        assign coll_flat[ch_offset(k, DATA_W) +: DATA_W] = coll[k];
    end

    // The last channel bypasses its collect slot so a complete frame can
    // land in the output register on the same edge its eop beat arrives.
    assign direct_frame = {wr_data, coll_flat[LAST_OFF-1:0]};

    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                coll[k] <= '0;
            end
        end else if (wr_en) begin
            coll[wr_idx] <= wr_data;
        end
    end

    // A load always leaves out_valid set, even when the previous word is
    // draining on the same edge, so back-to-back frames have no bubble.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load_direct) begin
            out_data  <= direct_frame;
            out_valid <= 1'b1;
        end else if (load_held) begin
            out_data  <= coll_flat;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rechannelizer.sv
// ---------------------------------------------------------------------------
// rechannelizer
// Reassembles an Avalon-ST stream of NUM_CH samples per frame (sop on
// channel 0, eop on channel NUM_CH-1) into one parallel word per frame,
// with frame-integrity checking and one frame of buffering.
//   clk, reset_n        : clock, synchronous active-low reset
//   in_data/in_valid/in_sop/in_eop/in_ready : serial sample stream
//   out_data/out_valid/out_ready : reassembled frame; channel k in
//                         bits [k*DATA_W +: DATA_W]
//   err_nosop           : pulse, beat outside a frame without sop
//   err_len             : pulse, short, long or restarted frame
//   err_count           : saturating count of all error pulses
// ---------------------------------------------------------------------------
module rechannelizer
    import rechannelizer_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int NUM_CH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic                     in_eop,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_nosop,
    output logic                     err_len,
    output logic [15:0]              err_count
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    err_cause_t         err_cause;
    logic               accept;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               load_direct;
    logic               load_held;
    logic               out_free;

    assign accept = in_valid && in_ready;

    channel_frame_buffer #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) u_buffer (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_data     (in_data),
        .load_direct (load_direct),
        .load_held   (load_held),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_free    (out_free)
    );

    // State register; error pulses are registered so they appear on the
    // cycle after the offending beat.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            err_nosop <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            err_nosop <= (err_cause == ERR_NOSOP);
            err_len   <= (err_cause == ERR_LEN);
        end
    end

    // The counter steps on the same edge that raises the pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (err_cause != ERR_NONE && err_count != ERR_COUNT_MAX) begin
            err_count <= err_count + 16'd1;
        end
    end

    // Next-state and buffer control. A sop beat always restarts the frame
    // at channel 0, whether it arrives in IDLE, COLLECT or DROP.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        err_cause   = ERR_NONE;
        wr_en       = 1'b0;
        wr_idx      = idx;
        load_direct = 1'b0;
        load_held   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_sop && in_eop) begin
                        err_cause = ERR_LEN;
                    end else if (in_sop) begin
                        wr_en      = 1'b1;
                        wr_idx     = '0;
                        idx_next   = ONE_IDX;
                        state_next = COLLECT;
                    end else begin
                        err_cause = ERR_NOSOP;
                    end
                end
            end

            COLLECT: begin
                if (accept) begin
                    if (in_sop) begin
                        err_cause = ERR_LEN;
                        wr_en     = 1'b1;
                        wr_idx    = '0;
                        idx_next  = ONE_IDX;
                    end else if (idx == LAST_IDX) begin
                        idx_next = '0;
                        if (!in_eop) begin
                            err_cause  = ERR_LEN;
                            state_next = DROP;
                        end else if (out_free) begin
                            load_direct = 1'b1;
                            state_next  = IDLE;
                        end else begin
                            // Park the last sample so the collect registers
                            // hold the whole frame until the output drains.
                            wr_en      = 1'b1;
                            wr_idx     = LAST_IDX;
                            state_next = FULL;
                        end
                    end else if (in_eop) begin
                        err_cause  = ERR_LEN;
                        idx_next   = '0;
                        state_next = IDLE;
                    end else begin
                        wr_en    = 1'b1;
                        idx_next = idx + ONE_IDX;
                    end
                end
            end

            DROP: begin
                if (accept) begin
                    if (in_sop) begin
                        wr_en      = 1'b1;
                        wr_idx     = '0;
                        idx_next   = ONE_IDX;
                        state_next = COLLECT;
                    end else if (in_eop) begin
                        state_next = IDLE;
                    end
                end
            end

            FULL: begin
                if (out_valid && out_ready) begin
                    load_held  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // in_ready depends on registered state only, never on out_ready.
    always_comb begin
        in_ready = reset_n && (state != FULL);
    end

endmodule

// File: tb/tb_rechannelizer.sv
// ---------------------------------------------------------------------------
// tb_rechannelizer
// Self-checking bench for rechannelizer (DATA_W=24, NUM_CH=2): a table of
// single-cycle vectors with hand-computed results, followed by hand-written
// sequences for backpressure, reset mid-frame / in FULL and counter
// saturation.
// ---------------------------------------------------------------------------
module tb_rechannelizer;

    localparam int DATA_W = 24;
    localparam int NUM_CH = 2;

    logic                     clk;
    logic                     reset_n;
    logic [DATA_W-1:0]        in_data;
    logic                     in_valid;
    logic                     in_sop;
    logic                     in_eop;
    logic                     in_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     err_nosop;
    logic                     err_len;
    logic [15:0]              err_count;

    int checks = 0;
    int errors = 0;

    rechannelizer #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_nosop (err_nosop),
        .err_len   (err_len),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        sop;
        logic        eop;
        logic [23:0] data;
        logic        ordy;
        logic        exp_ov;
        logic [47:0] exp_data;
        logic        exp_ir;
        logic        exp_nosop;
        logic        exp_len;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    // Transfers observed at the negedge ahead of the edge that performs them.
    logic        mon_en = 1'b0;
    logic [47:0] got[$];

    always @(negedge clk) begin
        if (mon_en && reset_n && out_valid && out_ready) begin
            got.push_back(out_data);
        end
    end

    function automatic vec_t mk(input logic v, input logic s, input logic e,
                                input logic [23:0] d, input logic r,
                                input logic ov, input logic [47:0] od,
                                input logic ir, input logic n, input logic l,
                                input logic [15:0] c);
        vec_t x;
        x.valid = v; x.sop = s; x.eop = e; x.data = d; x.ordy = r;
        x.exp_ov = ov; x.exp_data = od; x.exp_ir = ir;
        x.exp_nosop = n; x.exp_len = l; x.exp_cnt = c;
        return x;
    endfunction

    // Drive one cycle of inputs, clock it, and land 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic s, input logic e,
                                 input logic [23:0] d, input logic r);
        in_valid  = v;
        in_sop    = s;
        in_eop    = e;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag, input logic [15:0] cnt);
        checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, " out_data"},  64'(out_data),  64'd0);
        checkOutput({tag, " in_ready"},  64'(in_ready),  64'd0);
        checkOutput({tag, " err_nosop"}, 64'(err_nosop), 64'd0);
        checkOutput({tag, " err_len"},   64'(err_len),   64'd0);
        checkOutput({tag, " err_count"}, 64'(err_count), 64'(cnt));
    endtask

    localparam logic [47:0] FA = 48'h100002_100001;
    localparam logic [47:0] FB = 48'h200002_200001;
    localparam logic [47:0] FC = 48'h300002_300001;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset", 16'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("reset release in_ready", 64'(in_ready), 64'd1);

        // ---------------- table-driven vectors ----------------
        //           v  s  e  data        r  ov exp_data           ir n  l  cnt
        vecs.push_back(mk(1, 1, 0, 24'h000001, 1, 0, 48'h0,              1, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 1, 24'h000002, 1, 1, 48'h000002_000001,  1, 0, 0, 16'd0));
        vecs.push_back(mk(1, 1, 0, 24'h0ABCDE, 1, 0, 48'h0,              1, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 1, 24'h123456, 1, 1, 48'h123456_0ABCDE,  1, 0, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 24'h000000, 1, 0, 48'h0,              1, 0, 0, 16'd0));
        // beat without sop in IDLE
        vecs.push_back(mk(1, 0, 0, 24'h00FFFF, 1, 0, 48'h0,              1, 1, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 24'h000000, 1, 0, 48'h0,              1, 0, 0, 16'd1));
        // sop, sop, eop: restart on second sop
        vecs.push_back(mk(1, 1, 0, 24'h000001, 1, 0, 48'h0,              1, 0, 0, 16'd1));
        vecs.push_back(mk(1, 1, 0, 24'h000002, 1, 0, 48'h0,              1, 0, 1, 16'd2));
        vecs.push_back(mk(1, 0, 1, 24'h000003, 1, 1, 48'h000003_000002,  1, 0, 0, 16'd2));
        vecs.push_back(mk(0, 0, 0, 24'h000000, 1, 0, 48'h0,              1, 0, 0, 16'd2));
        // long frame, dropped until eop, then a good frame
        vecs.push_back(mk(1, 1, 0, 24'h000010, 1, 0, 48'h0,              1, 0, 0, 16'd2));
        vecs.push_back(mk(1, 0, 0, 24'h000011, 1, 0, 48'h0,              1, 0, 1, 16'd3));
        vecs.push_back(mk(1, 0, 0, 24'h000012, 1, 0, 48'h0,              1, 0, 0, 16'd3));
        vecs.push_back(mk(1, 0, 1, 24'h000013, 1, 0, 48'h0,              1, 0, 0, 16'd3));
        vecs.push_back(mk(1, 1, 0, 24'h000020, 1, 0, 48'h0,              1, 0, 0, 16'd3));
        vecs.push_back(mk(1, 0, 1, 24'h000021, 1, 1, 48'h000021_000020,  1, 0, 0, 16'd3));
        vecs.push_back(mk(0, 0, 0, 24'h000000, 1, 0, 48'h0,              1, 0, 0, 16'd3));
        // sop+eop on one beat in IDLE
        vecs.push_back(mk(1, 1, 1, 24'h0000AA, 1, 0, 48'h0,              1, 0, 1, 16'd4));
        vecs.push_back(mk(0, 0, 0, 24'h000000, 1, 0, 48'h0,              1, 0, 0, 16'd4));
        // eop without sop in IDLE
        vecs.push_back(mk(1, 0, 1, 24'h0000BB, 1, 0, 48'h0,              1, 1, 0, 16'd5));
        // sop with in_valid low must be ignored
        vecs.push_back(mk(0, 1, 0, 24'h0000CC, 1, 0, 48'h0,              1, 0, 0, 16'd5));
        vecs.push_back(mk(1, 0, 1, 24'h0000DD, 1, 0, 48'h0,              1, 1, 0, 16'd6));
        vecs.push_back(mk(0, 0, 0, 24'h000000, 1, 0, 48'h0,              1, 0, 0, 16'd6));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].sop, vecs[i].eop,
                          vecs[i].data, vecs[i].ordy);
            checkOutput($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                checkOutput($sformatf("row%0d out_data", i), 64'(out_data), 64'(vecs[i].exp_data));
            end
            checkOutput($sformatf("row%0d in_ready", i),  64'(in_ready),  64'(vecs[i].exp_ir));
            checkOutput($sformatf("row%0d err_nosop", i), 64'(err_nosop), 64'(vecs[i].exp_nosop));
            checkOutput($sformatf("row%0d err_len", i),   64'(err_len),   64'(vecs[i].exp_len));
            checkOutput($sformatf("row%0d err_count", i), 64'(err_count), 64'(vecs[i].exp_cnt));
        end

        // ---------------- backpressure: 10 cycles of out_ready=0 ----------------
        got.delete();
        mon_en = 1'b1;
        applyStimulus(1, 1, 0, 24'h100001, 0);
        checkOutput("bp A0 out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1, 0, 1, 24'h100002, 0);
        checkOutput("bp A1 out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp A1 out_data",  64'(out_data),  64'(FA));
        checkOutput("bp A1 in_ready",  64'(in_ready),  64'd1);
        applyStimulus(1, 1, 0, 24'h200001, 0);
        checkOutput("bp B0 out_data",  64'(out_data),  64'(FA));
        applyStimulus(1, 0, 1, 24'h200002, 0);
        checkOutput("bp B1 in_ready",  64'(in_ready),  64'd0);
        checkOutput("bp B1 out_data",  64'(out_data),  64'(FA));
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1, 1, 0, 24'h300001, 0);
            checkOutput($sformatf("bp stall%0d in_ready", c),  64'(in_ready),  64'd0);
            checkOutput($sformatf("bp stall%0d out_valid", c), 64'(out_valid), 64'd1);
            checkOutput($sformatf("bp stall%0d out_data", c),  64'(out_data),  64'(FA));
        end
        applyStimulus(1, 1, 0, 24'h300001, 1);
        checkOutput("bp release out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp release out_data",  64'(out_data),  64'(FB));
        checkOutput("bp release in_ready",  64'(in_ready),  64'd1);
        applyStimulus(1, 1, 0, 24'h300001, 1);
        checkOutput("bp C0 out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1, 0, 1, 24'h300002, 1);
        checkOutput("bp C1 out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp C1 out_data",  64'(out_data),  64'(FC));
        applyStimulus(0, 0, 0, 24'h0, 1);
        mon_en = 1'b0;
        checkOutput("bp delivered count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            checkOutput("bp order 0", 64'(got[0]), 64'(FA));
            checkOutput("bp order 1", 64'(got[1]), 64'(FB));
            checkOutput("bp order 2", 64'(got[2]), 64'(FC));
        end
        checkOutput("bp err_count", 64'(err_count), 64'd6);

        // ---------------- reset in COLLECT ----------------
        applyStimulus(1, 1, 0, 24'h0000E1, 1);
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 24'h0, 1);
        checkIdleOutputs("rst collect", 16'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("rst collect release in_ready", 64'(in_ready), 64'd1);
        applyStimulus(1, 0, 1, 24'h0000E2, 1);
        checkOutput("rst collect eop out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst collect eop err_nosop", 64'(err_nosop), 64'd1);
        checkOutput("rst collect eop err_count", 64'(err_count), 64'd1);
        applyStimulus(0, 0, 0, 24'h0, 1);

        // ---------------- reset in FULL ----------------
        applyStimulus(1, 1, 0, 24'h0000F1, 0);
        applyStimulus(1, 0, 1, 24'h0000F2, 0);
        applyStimulus(1, 1, 0, 24'h0000F3, 0);
        applyStimulus(1, 0, 1, 24'h0000F4, 0);
        checkOutput("full in_ready", 64'(in_ready), 64'd0);
        checkOutput("full out_data", 64'(out_data), 64'h0000F2_0000F1);
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 24'h0, 0);
        checkIdleOutputs("rst full", 16'd0);
        applyStimulus(1, 1, 0, 24'h0000F5, 1);
        checkIdleOutputs("rst full hold", 16'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("rst full release in_ready", 64'(in_ready), 64'd1);
        applyStimulus(0, 0, 0, 24'h0, 1);
        checkOutput("rst full no output", 64'(out_valid), 64'd0);
        applyStimulus(1, 1, 0, 24'h0000A1, 1);
        applyStimulus(1, 0, 1, 24'h0000A2, 1);
        checkOutput("post reset frame valid", 64'(out_valid), 64'd1);
        checkOutput("post reset frame data",  64'(out_data),  64'h0000A2_0000A1);
        checkOutput("post reset err_count",   64'(err_count), 64'd0);

        // ---------------- err_count saturation ----------------
        in_valid  = 1'b1;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_data   = 24'h00ABCD;
        out_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        checkOutput("sat err_count", 64'(err_count), 64'hFFFF);
        checkOutput("sat err_nosop", 64'(err_nosop), 64'd1);
        applyStimulus(0, 0, 0, 24'h0, 1);
        checkOutput("sat hold err_count", 64'(err_count), 64'hFFFF);
        checkOutput("sat hold err_nosop", 64'(err_nosop), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
